dynamic_infoframe_packet: RTL
=============================

Name: dynamic_infoframe_packet

Overview:
- Runtime-loadable HDMI InfoFrame generator: a generalised successor to the fixed-payload metadata packet blocks.
- Primary use is the Dynamic Range and Mastering (HDR) InfoFrame, type 0x87; TYPE/VERSION/LENGTH are parameters.
- Control logic writes payload bytes into a shadow buffer and then commits. The checksum is computed sequentially, and the new payload is swapped into the active buffer only at a frame boundary.
- Outputs feed the packet assembler unchanged: header plus four 56-bit subpackets.

Parameters:
- TYPE, 7'h07: InfoFrame type; header byte 0 = {1'b1, TYPE}.
- VERSION, 8'h01: header byte 1.
- LENGTH, 5'd26: payload length in bytes, range 1..27; header byte 2 = {3'b0, LENGTH}.

Ports:
- clk_pixel  in  1  pixel clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe for the shadow buffer.
- wr_addr  in  5  payload byte index PB1..PB27; 0 and values above 27 are ignored.
- wr_data  in  8  payload byte.
- commit  in  1  single-cycle request to checksum the shadow buffer and schedule the swap.
- frame_start  in  1  one-cycle pulse at the frame boundary (first pixel of vblank).
- busy  out  1  high while the FSM is in SUM or PENDING.
- packet_valid  out  1  low after reset; set at the first swap; stays high thereafter.
- header  out  24  {LENGTH byte, VERSION, {1,TYPE}}; constant.
- sub  out  4x56  sub[i] = {PB[6+7i], ..., PB[7i]}; PB0 is the checksum.

Behaviour:
- Reset (async) does all of the following:
  - FSM to IDLE; busy=0; packet_valid=0.
  - Shadow and active payload buffers cleared to 0.
  - Active checksum = (-(header byte sum)) mod 256, so sub is a well-formed all-zero packet.
- Writes:
  - Accepted only in IDLE: shadow[wr_addr] <= wr_data on the next edge.
  - Writes while busy are dropped; the shadow is frozen during SUM and PENDING.
  - Addresses above LENGTH are stored, but they never reach the active buffer and are excluded from the checksum.
- FSM states:
  - IDLE: commit=1 → SUM; idx=1; acc = header byte sum (8-bit).
  - SUM: each cycle acc += shadow[idx], idx++. When idx==LENGTH the last byte is added and the state moves to PENDING with csum_next = ~acc + 1. SUM lasts exactly LENGTH cycles. frame_start is ignored in SUM.
  - PENDING: on frame_start, copy shadow[1..LENGTH] to active; active PB bytes above LENGTH are forced to 0; active checksum <= csum_next; packet_valid <= 1; go to IDLE. New values appear on sub the cycle after the frame_start edge.
- commit in SUM or PENDING is ignored; it is not queued.
- commit and wr_en in the same IDLE cycle: the write lands and SUM begins the next cycle, so the written byte is included in the checksum.
- All arithmetic is modulo 256. Invariant: the sum of the three header bytes, the checksum and PB1..PB27 in the active outputs is 0 mod 256.
- Outputs are registered from the active buffer, so there is no combinational path from wr_* to sub.
- Reset mid-SUM or mid-PENDING drops the update and applies the full reset state.

Decomposition:
- Package hdmi_infoframe_pkg:
  - Typedef infoframe_bytes_t, an array of 28  8-bit bytes.
  - Function infoframe_header(type, version, length) returning 24 bits.
  - Function pack_subpackets(bytes) returning 4x56.
  - Localparams for the type codes: 0x82 AVI, 0x83 SPD, 0x84 audio, 0x87 DRM.
- One sub-module, infoframe_checksum_seq: the IDLE/SUM/PENDING FSM, idx counter and accumulator. It takes start, a byte-read port and header_sum, and returns done plus csum.

Test Plan:
- Defaults, after reset: header=24'h1A0187; sub[0][7:0]=8'h5E; all other sub bytes 0; packet_valid=0; busy=0.
- Write PB1=8'h02, PB2=8'h00, then commit: busy rises the next cycle and PENDING is reached after 26 cycles. frame_start then gives sub[0][15:8]=8'h02, sub[0][7:0]=8'h5C, packet_valid=1.
- frame_start during SUM (cycle 10 after commit): sub unchanged. A second frame_start after PENDING applies the update.
- Write PB3=8'hFF while busy: the write is dropped and the applied checksum still equals 8'h5C.
- Write addr 27=8'h55 with LENGTH=26: sub[3][55:48]=0 and the checksum is unaffected.
- Assert reset during PENDING: outputs return to the default packet with checksum 5E and packet_valid=0. A later frame_start causes no swap.

Source files
------------

// File: rtl/hdmi_infoframe_pkg.sv
// hdmi_infoframe_pkg: shared InfoFrame types, header builder and subpacket packing.
package hdmi_infoframe_pkg;

    localparam logic [7:0] INFOFRAME_AVI   = 8'h82;
    localparam logic [7:0] INFOFRAME_SPD   = 8'h83;
    localparam logic [7:0] INFOFRAME_AUDIO = 8'h84;
    localparam logic [7:0] INFOFRAME_DRM   = 8'h87;

    // Byte 0 is the checksum (PB0), bytes 1..27 are PB1..PB27.
    typedef logic [27:0][7:0] infoframe_bytes_t;

    typedef enum logic [1:0] {CS_IDLE, CS_SUM, CS_PENDING} cs_state_t;

    function automatic logic [23:0] infoframe_header(input logic [6:0] if_type,
                                                     input logic [7:0] version,
                                                     input logic [4:0] length);
        return {3'b000, length, version, 1'b1, if_type};
    endfunction

    function automatic logic [3:0][55:0] pack_subpackets(input infoframe_bytes_t bytes);
        logic [3:0][55:0] p;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 7; j++)
                p[i][8*j +: 8] = bytes[7*i + j];
        return p;
    endfunction

endpackage

// File: rtl/infoframe_checksum_seq.sv
// infoframe_checksum_seq: walks PB1..PB(LENGTH) one byte per cycle, then holds the
// resulting checksum until the frame boundary releases it.
module infoframe_checksum_seq
    import hdmi_infoframe_pkg::*;
#(
    parameter logic [4:0] LENGTH = 5'd26
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic       start,
    input  logic       frame_start,
    input  logic [7:0] header_sum,
    input  logic [7:0] rd_data,
    output logic [4:0] rd_addr,
    output logic       busy,
    output logic       done,
    output logic [7:0] csum
);

    cs_state_t  state_q, state_d;
    logic [4:0] idx_q, idx_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] csum_q, csum_d;

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state_q <= CS_IDLE;
            idx_q   <= 5'd1;
            acc_q   <= 8'h00;
            csum_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            csum_q  <= csum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        csum_d  = csum_q;
        case (state_q)
            CS_IDLE: if (start) begin
                state_d = CS_SUM;
                idx_d   = 5'd1;
                acc_d   = header_sum;
            end
            CS_SUM: begin
                acc_d = acc_q + rd_data;
                idx_d = idx_q + 5'd1;
                if (idx_q == LENGTH) begin
                    state_d = CS_PENDING;
                    csum_d  = ~acc_d + 8'd1;
                end
            end
            CS_PENDING: state_d = frame_start ? CS_IDLE : CS_PENDING;
            default: state_d = CS_IDLE;
        endcase
    end

    assign rd_addr = idx_q;
    assign busy    = state_q != CS_IDLE;
    assign done    = state_q == CS_PENDING;
    assign csum    = csum_q;

endmodule

// File: rtl/dynamic_infoframe_packet.sv
// dynamic_infoframe_packet: shadow/active InfoFrame payload with a sequential checksum
// and a frame-synchronous swap into the registered subpacket outputs.
module dynamic_infoframe_packet
    import hdmi_infoframe_pkg::*;
#(
    parameter logic [6:0] TYPE    = 7'h07,
    parameter logic [7:0] VERSION = 8'h01,
    parameter logic [4:0] LENGTH  = 5'd26
) (
    input  logic             clk_pixel,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [4:0]       wr_addr,
    input  logic [7:0]       wr_data,
    input  logic             commit,
    input  logic             frame_start,
    output logic             busy,
    output logic             packet_valid,
    output logic [23:0]      header,
    output logic [3:0][55:0] sub
);

    localparam logic [23:0] HDR       = infoframe_header(TYPE, VERSION, LENGTH);
    localparam logic [7:0]  HDR_SUM   = HDR[7:0] + HDR[15:8] + HDR[23:16];
    localparam logic [7:0]  RST_CSUM  = ~HDR_SUM + 8'd1;

    infoframe_bytes_t shadow, active;
    logic [4:0]       rd_addr;
    logic [7:0]       csum;
    logic             done;
    logic             swap;

    infoframe_checksum_seq #(.LENGTH(LENGTH)) u_csum (
        .clk_pixel   (clk_pixel),
        .reset       (reset),
        .start       (commit),
        .frame_start (frame_start),
        .header_sum  (HDR_SUM),
        .rd_data     (shadow[rd_addr]),
        .rd_addr     (rd_addr),
        .busy        (busy),
        .done        (done),
        .csum        (csum)
    );

    assign swap = done & frame_start;

    // The shadow stays frozen while a checksum is in flight so the sum matches what is swapped.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset)
            shadow <= '0;
        else if (wr_en && !busy && wr_addr != 5'd0 && wr_addr <= 5'd27)
            shadow[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            active       <= {216'd0, RST_CSUM};
            packet_valid <= 1'b0;
        end else if (swap) begin
            for (int k = 1; k < 28; k++)
                active[k] <= (k <= int'(LENGTH)) ? shadow[k] : 8'h00;
            active[0]    <= csum;
            packet_valid <= 1'b1;
        end
    end

    assign header = HDR;
    assign sub    = pack_subpackets(active);

endmodule
